riscv_data_mem_responder: RTL and testbench

- Responder (slave) end of the CPU load/store data-memory interface.
- Accepts one RV32I load/store request at a time over a valid/ready handshake.
- Applies a configurable number of wait states, then performs byte/half/word access on an internal little-endian word array.
- Returns read data or an error flag over a second valid/ready handshake. Gives the multi-cycle CPU a realistic, stallable memory.

---
 rtl/riscv_data_mem_responder_if.sv | 23 ++
 rtl/riscv_data_mem_responder.sv | 137 +++++++++++++
 tb/tb_riscv_data_mem_responder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_data_mem_responder_if.sv
// Load/store data-memory bus between the CPU (master) and the memory responder (slave).
interface riscv_data_mem_responder_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_FUNCT3, REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_FUNCT3, REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );
endinterface

// File: rtl/riscv_data_mem_responder.sv
// Stallable RV32I data memory: one request at a time, WAIT_CYCLES wait states,
// byte/half/word access on a little-endian word array with error reporting.
module riscv_data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  riscv_data_mem_responder_if.slave    bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [2:0]         f3_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem [DEPTH_WORDS];

  logic [IDX_W-1:0]   idx;
  logic [31:0]        rd_word;
  logic               err_w;

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr);
    logic bad_f3;
    logic misal;
    logic range;
    bad_f3 = we ? !(f3 inside {3'b000, 3'b001, 3'b010})
                : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal  = ((f3[1:0] == 2'b01) && addr[0]) ||
             ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    range  = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    return bad_f3 || misal || range;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (f3[1:0])
      2'b00:   mask = 32'h0000_00FF << {lane, 3'b000};
      2'b01:   mask = 32'h0000_FFFF << {lane, 3'b000};
      default: mask = 32'hFFFF_FFFF;
    endcase
    data = wdata << {lane, 3'b000};
    return (old & ~mask) | (data & mask);
  endfunction

  assign idx     = addr_q[IDX_W+1:2];
  assign rd_word = mem[idx];
  assign err_w   = access_err(we_q, f3_q, addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.REQ_VALID) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(WAIT_CYCLES)) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_d   = '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers: cleared asynchronously, which also aborts
  // any request still in WAIT/ACCESS before its store can commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_ACCESS) begin
        err_q   <= err_w;
        rdata_q <= (err_w || we_q) ? 32'h0 : load_extend(rd_word, f3_q, addr_q[1:0]);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && bus.REQ_VALID) begin
      we_q    <= bus.REQ_WE;
      addr_q  <= bus.REQ_ADDR;
      f3_q    <= bus.REQ_FUNCT3;
      wdata_q <= bus.REQ_WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_ACCESS && we_q && !err_w)
      mem[idx] <= store_merge(rd_word, wdata_q, f3_q, addr_q[1:0]);
  end

  assign bus.REQ_READY = (state_q == S_IDLE) && !RST;
  assign bus.RSP_VALID = (state_q == S_RESP);
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// Bench for riscv_data_mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance
// checked against a byte-array reference model.
module tb_riscv_data_mem_responder;

  localparam int DEPTH = 256;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  riscv_data_mem_responder_if ia ();
  riscv_data_mem_responder_if ib ();

  riscv_data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ia)
  );
  riscv_data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ib)
  );

  int          req_sel   = 0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [2:0]  req_f3    = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  assign ia.REQ_VALID  = req_valid && (req_sel == 0);
  assign ib.REQ_VALID  = req_valid && (req_sel == 1);
  assign ia.RSP_READY  = rsp_ready && (req_sel == 0);
  assign ib.RSP_READY  = rsp_ready && (req_sel == 1);
  assign ia.REQ_WE     = req_we;
  assign ib.REQ_WE     = req_we;
  assign ia.REQ_ADDR   = req_addr;
  assign ib.REQ_ADDR   = req_addr;
  assign ia.REQ_FUNCT3 = req_f3;
  assign ib.REQ_FUNCT3 = req_f3;
  assign ia.REQ_WDATA  = req_wdata;
  assign ib.REQ_WDATA  = req_wdata;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  assign m_req_ready = (req_sel == 1) ? ib.REQ_READY : ia.REQ_READY;
  assign m_rsp_valid = (req_sel == 1) ? ib.RSP_VALID : ia.RSP_VALID;
  assign m_rsp_err   = (req_sel == 1) ? ib.RSP_ERR   : ia.RSP_ERR;
  assign m_rsp_rdata = (req_sel == 1) ? ib.RSP_RDATA : ia.RSP_RDATA;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl [2][DEPTH*4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access size and legality from funct3.
  function automatic void model(input int sel, input logic we, input logic [31:0] addr,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd);
    int size;
    bit legal;
    longint unsigned v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal || (addr % size != 0) || (addr / 4 >= 32'(DEPTH));
    rd    = '0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < size; b++) mdl[sel][int'(addr) + b] = wd[8*b +: 8];
      end else begin
        v = 0;
        for (int b = 0; b < size; b++) v = v | (longint'(mdl[sel][int'(addr) + b]) << (8*b));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (64'hFFFF_FFFF << (8*size));
        rd = v[31:0];
      end
    end
  endfunction

  task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd_o, output logic err_o);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          t;
    int          lat;
    model(sel, we, addr, f3, wd, exp_err, exp_rd);
    @(negedge CLK);
    req_sel = sel; req_we = we; req_addr = addr; req_f3 = f3; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b0;
    t = 0;
    while (m_req_ready !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
    check("req_ready_idle", 32'(m_req_ready), 32'd1);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    if (hold < 0) rsp_ready = 1'b1;
    lat = 0;
    do begin @(posedge CLK); #1; lat++; end while (m_rsp_valid !== 1'b1 && lat < 20);
    check("latency", 32'(lat), (sel == 0) ? 32'd3 : 32'd1);
    check("rsp_valid", 32'(m_rsp_valid), 32'd1);
    check("rsp_rdata", m_rsp_rdata, exp_rd);
    check("rsp_err", 32'(m_rsp_err), 32'(exp_err));
    check("req_ready_busy", 32'(m_req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("hold_valid", 32'(m_rsp_valid), 32'd1);
      check("hold_rdata", m_rsp_rdata, exp_rd);
      check("hold_err", 32'(m_rsp_err), 32'(exp_err));
      check("hold_req_ready", 32'(m_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(m_rsp_valid), 32'd0);
    check("req_ready_back", 32'(m_req_ready), 32'd1);
    rd_o  = exp_rd;
    err_o = exp_err;
    if (!exp_err && !we) rd_o = m_rsp_rdata;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    #3;
    check("rst_req_ready_a", 32'(ia.REQ_READY), 32'd0);
    check("rst_rsp_valid_a", 32'(ia.RSP_VALID), 32'd0);
    check("rst_rdata_a", ia.RSP_RDATA, 32'd0);
    check("rst_err_a", 32'(ia.RSP_ERR), 32'd0);
    check("rst_req_ready_b", 32'(ib.REQ_READY), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_ready_a", 32'(ia.REQ_READY), 32'd1);
    check("post_rst_ready_b", 32'(ib.REQ_READY), 32'd1);

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++) do_req(s, 1'b1, 32'(w * 4), 3'b010, 32'h0, 0, rd, er);

    do_req(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, rd, er);
    do_req(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, rd, er);
    check("lw_10", rd, 32'hDEADBEEF);

    do_req(0, 1'b1, 32'h21, 3'b000, 32'h80, 0, rd, er);
    do_req(0, 1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er);
    check("sb_lw_20", rd, 32'h0000_8000);
    do_req(0, 1'b0, 32'h21, 3'b000, 32'h0, 0, rd, er);
    check("lb_21", rd, 32'hFFFF_FF80);
    do_req(0, 1'b0, 32'h21, 3'b100, 32'h0, -1, rd, er);
    check("lbu_21", rd, 32'h0000_0080);

    do_req(0, 1'b1, 32'h20, 3'b010, 32'h11223344, 0, rd, er);
    do_req(0, 1'b1, 32'h22, 3'b001, 32'h0000ABCD, 0, rd, er);
    do_req(0, 1'b0, 32'h20, 3'b010, 32'h0, 0, rd, er);
    check("sh_lw_20", rd, 32'hABCD_3344);
    do_req(0, 1'b0, 32'h22, 3'b001, 32'h0, 0, rd, er);
    check("lh_22", rd, 32'hFFFF_ABCD);
    do_req(0, 1'b0, 32'h22, 3'b101, 32'h0, 0, rd, er);
    check("lhu_22", rd, 32'h0000_ABCD);

    do_req(0, 1'b0, 32'h13, 3'b001, 32'h0, 0, rd, er);
    check("lh_13_err", 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h12, 3'b010, 32'h0, 0, rd, er);
    check("lw_12_err", 32'(er), 32'd1);
    do_req(0, 1'b1, 32'(DEPTH * 4), 3'b010, 32'hCAFEF00D, 0, rd, er);
    check("sw_oob_err", 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h10, 3'b011, 32'h0, 0, rd, er);
    check("ld_f3_011_err", 32'(er), 32'd1);
    do_req(0, 1'b1, 32'h12, 3'b010, 32'h55555555, 0, rd, er);
    do_req(0, 1'b0, 32'h10, 3'b010, 32'h0, 5, rd, er);
    check("lw_10_unchanged", rd, 32'hDEADBEEF);

    // Reset while a store sits in WAIT: it must never commit.
    @(negedge CLK);
    req_sel = 0; req_we = 1'b1; req_addr = 32'h30; req_f3 = 3'b010;
    req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    #1;
    check("midrst_valid", 32'(ia.RSP_VALID), 32'd0);
    check("midrst_rdata", ia.RSP_RDATA, 32'd0);
    check("midrst_err", 32'(ia.RSP_ERR), 32'd0);
    check("midrst_ready", 32'(ia.REQ_READY), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    check("midrst_release_ready", 32'(ia.REQ_READY), 32'd1);
    do_req(0, 1'b0, 32'h30, 3'b010, 32'h0, 0, rd, er);
    check("lw_30_aborted", rd, 32'h0);

    do_req(1, 1'b1, 32'h14, 3'b010, 32'hA5A5_0F0F, 0, rd, er);
    do_req(1, 1'b0, 32'h16, 3'b000, 32'h0, 2, rd, er);
    check("w0_lb_16", rd, 32'hFFFF_FFA5);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          s;
      s  = (i % 4 == 3) ? 1 : 0;
      a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      do_req(s, 1'($urandom_range(0, 1)), a, f3, $urandom, int'($urandom_range(0, 2)) - 1, rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
